// File: rtl/axis_step_gen.sv
// Single-axis STEP/DIR generator: runs one trapezoidal move from precomputed
// phase boundaries and step-period parameters, handshaking on start/finish.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | latch move parameters and direction
// RUN   | counting periods, emitting STEP pulses
// DRAIN | tt expired; let the in-flight STEP finish, then DONE
// ABORT | start dropped; let the in-flight STEP finish, then IDLE
// DONE  | finish high until start drops
module axis_step_gen #(
    parameter int PULSE_W = 2,
    parameter int TW      = 64,
    parameter int PW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [TW-1:0] timing [0:3],
    input  logic [PW-1:0] steps,
    input  logic [PW-1:0] period_start,
    input  logic [PW-1:0] period_min,
    input  logic [PW-1:0] period_delta,
    input  logic          dir_in,
    output logic          step,
    output logic          dir,
    output logic          busy,
    output logic          finish,
    output logic          timeout
);

    localparam int CW = $clog2(PULSE_W + 1);
    localparam logic [PW-1:0] P_FLOOR = PW'(PULSE_W + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_ABORT, S_DONE
    } state_t;

    state_t state, state_nx;

    logic [TW-1:0] t1_r, t2_r, t3_r, tt_r, elapsed;
    logic [PW-1:0] steps_r, ps_r, pm_r, pd_r;
    logic [PW-1:0] per_r, pcnt, step_cnt, next_per;
    logic [CW-1:0] pw_cnt;

    logic pulse_end, pulse_free, steps_left, tmo_hit, fire, tmo_set;
    logic [PW-1:0] dec_p, inc_p;
    logic [PW:0]   inc_sum;

    // Periods shorter than PULSE_W+1 would merge consecutive STEP pulses.
    function automatic logic [PW-1:0] clamp_p(input logic [PW-1:0] p);
        return (p < P_FLOOR) ? P_FLOOR : p;
    endfunction

    assign pulse_end  = step && (pw_cnt == CW'(1));
    assign pulse_free = !step || pulse_end;
    assign steps_left = (step_cnt != steps_r);
    assign tmo_hit    = (elapsed >= tt_r);
    assign fire       = (state == S_RUN) && start && steps_left && !tmo_hit
                        && (pcnt == PW'(1));
    assign tmo_set    = (state == S_RUN) && start && steps_left && tmo_hit;

    always_comb begin
        dec_p   = (per_r > pd_r) ? (per_r - pd_r) : '0;
        dec_p   = (dec_p < pm_r) ? pm_r : dec_p;
        inc_sum = {1'b0, per_r} + {1'b0, pd_r};
        inc_p   = (inc_sum > {1'b0, ps_r}) ? ps_r : inc_sum[PW-1:0];
        if (elapsed < t1_r)
            next_per = clamp_p(dec_p);
        else if (elapsed >= t2_r && elapsed < t3_r)
            next_per = clamp_p(inc_p);
        else
            next_per = per_r;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_LOAD;
            S_LOAD: begin
                if (!start)
                    state_nx = S_IDLE;
                else if (steps == '0)
                    state_nx = S_DONE;
                else
                    state_nx = S_RUN;
            end
            S_RUN: begin
                if (!start)
                    state_nx = pulse_free ? S_IDLE : S_ABORT;
                else if (!steps_left && pulse_free)
                    state_nx = S_DONE;
                else if (steps_left && tmo_hit)
                    state_nx = pulse_free ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                if (!start)
                    state_nx = pulse_free ? S_IDLE : S_ABORT;
                else if (pulse_free)
                    state_nx = S_DONE;
            end
            S_ABORT: if (pulse_free) state_nx = S_IDLE;
            S_DONE:  if (!start) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            t1_r     <= '0;
            t2_r     <= '0;
            t3_r     <= '0;
            tt_r     <= '0;
            steps_r  <= '0;
            ps_r     <= '0;
            pm_r     <= '0;
            pd_r     <= '0;
            per_r    <= '0;
            pcnt     <= '0;
            step_cnt <= '0;
            elapsed  <= '0;
            dir      <= 1'b0;
            timeout  <= 1'b0;
        end else if (state == S_LOAD) begin
            t1_r     <= timing[0];
            t2_r     <= timing[1];
            t3_r     <= timing[2];
            tt_r     <= timing[3];
            steps_r  <= steps;
            ps_r     <= clamp_p(period_start);
            pm_r     <= period_min;
            pd_r     <= period_delta;
            per_r    <= clamp_p(period_start);
            pcnt     <= clamp_p(period_start);
            step_cnt <= '0;
            elapsed  <= '0;
            dir      <= dir_in;
            timeout  <= 1'b0;
        end else if (state == S_RUN) begin
            if (elapsed != '1)
                elapsed <= elapsed + TW'(1);
            if (tmo_set)
                timeout <= 1'b1;
            if (fire) begin
                per_r    <= next_per;
                pcnt     <= next_per;
                step_cnt <= step_cnt + PW'(1);
            end else if (pcnt != '0) begin
                pcnt <= pcnt - PW'(1);
            end
        end
    end

    // The pulse timer runs independently of state so DRAIN/ABORT never cut a STEP short.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step   <= 1'b0;
            pw_cnt <= '0;
        end else if (fire) begin
            step   <= 1'b1;
            pw_cnt <= CW'(PULSE_W);
        end else if (step) begin
            if (pw_cnt == CW'(1))
                step <= 1'b0;
            else
                pw_cnt <= pw_cnt - CW'(1);
        end
    end

    assign busy   = (state == S_LOAD) || (state == S_RUN) ||
                    (state == S_DRAIN) || (state == S_ABORT);
    assign finish = (state == S_DONE);

endmodule
